// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a sign fix on the last step.
// One operation in flight; request/result use valid/ready handshakes.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  input  logic            result_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_prod;   // {accumulator, remaining multiplier bits}
  logic [XLEN-1:0]   r_dsor;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_rem;    // partial remainder (always < divisor)
  logic [XLEN-1:0]   r_quo;    // dividend bits shifting out, quotient bits in
  logic [XLEN-1:0]   r_result;

  // Request decode: which operands are signed and what sign the result takes
  logic            w_is_div;
  logic            w_signed_a;
  logic            w_signed_b;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_res_neg;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_is_div   = funct3[2];
  assign w_signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sign_a   = w_signed_a & op_a[XLEN-1];
  assign w_sign_b   = w_signed_b & op_b[XLEN-1];
  assign w_mag_a    = w_sign_a ? -op_a : op_a;
  assign w_mag_b    = w_sign_b ? -op_b : op_b;
  // Remainder follows the dividend; everything else is the product of signs
  assign w_res_neg  = (w_is_div && funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
  assign w_div_zero = w_is_div && (op_b == '0);
  assign w_ovf      = w_is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
  assign w_special  = w_div_zero || w_ovf;

  // Architectural results for divide-by-zero and signed overflow
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = funct3[1] ? op_a : '1;
    end else begin
      w_special_res = funct3[1] ? '0 : op_a;
    end
  end

  // One iteration of each datapath
  logic [XLEN:0]     w_add;
  logic [2*XLEN-1:0] w_prod_step;
  logic [XLEN:0]     w_rem_shift;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_rem_step;
  logic [XLEN-1:0]   w_quo_step;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;
  logic              w_last;

  assign w_add       = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_dsor};
  assign w_prod_step = r_prod[0] ? {w_add, r_prod[XLEN-1:1]}
                                 : {1'b0, r_prod[2*XLEN-1:1]};
  assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial     = w_rem_shift - {1'b0, r_dsor};
  assign w_rem_step  = w_trial[XLEN] ? w_rem_shift[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quo_step  = {r_quo[XLEN-2:0], ~w_trial[XLEN]};

  assign w_prod_fix  = r_neg ? -w_prod_step : w_prod_step;
  assign w_quo_fix   = r_neg ? -w_quo_step  : w_quo_step;
  assign w_rem_fix   = r_neg ? -w_rem_step  : w_rem_step;
  assign w_last      = (r_cnt == CNT_W'(XLEN - 1));

  // Pick the output word for the latched operation from the final iteration
  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:                 w_final = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo_fix;
      default:                w_final = w_rem_fix;
    endcase
  end

  // Control FSM and iterative datapath; flush wins over every other event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_dsor   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_op   <= funct3;
            r_neg  <= w_res_neg;
            r_cnt  <= '0;
            r_prod <= {{XLEN{1'b0}}, w_mag_a};
            r_dsor <= w_mag_b;
            r_rem  <= '0;
            r_quo  <= w_mag_a;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_prod <= w_prod_step;
          r_rem  <= w_rem_step;
          r_quo  <= w_quo_step;
          if (w_last) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at XLEN=32, 8 and 64: directed vectors,
// handshake/flush/reset sequences and random operands against an arithmetic model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-instance stimulus (index 0: XLEN=32, 1: XLEN=8, 2: XLEN=64)
  logic [2:0]  sv = '0;
  logic [2:0]  rr = '0;
  logic [2:0]  fl = '0;
  logic [2:0]  f3_32 = '0, f3_8 = '0, f3_64 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [63:0] a64 = '0, b64 = '0;
  wire  [2:0]  sr, bz, rv;
  wire  [31:0] res32;
  wire  [7:0]  res8;
  wire  [63:0] res64;

  muldiv_unit #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]), .funct3(f3_32),
    .op_a(a32), .op_b(b32), .flush(fl[0]), .busy(bz[0]), .result_valid(rv[0]),
    .result(res32), .result_ready(rr[0]));
  muldiv_unit #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]), .funct3(f3_8),
    .op_a(a8), .op_b(b8), .flush(fl[1]), .busy(bz[1]), .result_valid(rv[1]),
    .result(res8), .result_ready(rr[1]));
  muldiv_unit #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(sr[2]), .funct3(f3_64),
    .op_a(a64), .op_b(b64), .flush(fl[2]), .busy(bz[2]), .result_valid(rv[2]),
    .result(res64), .result_ready(rr[2]));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int width_of(int idx);
    return (idx == 0) ? 32 : (idx == 1) ? 8 : 64;
  endfunction

  function automatic logic [63:0] wmask(int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] get_res(int idx);
    case (idx)
      0:       return {32'd0, res32};
      1:       return {56'd0, res8};
      default: return res64;
    endcase
  endfunction

  // Reference: M-extension semantics in wide signed integer arithmetic
  function automatic logic [63:0] ref_model(int w, logic [2:0] f, logic [63:0] a, logic [63:0] b);
    logic [63:0] mask = wmask(w);
    logic signed [129:0] ua, ub, sa, sb, r;
    ua = {66'd0, a & mask};
    ub = {66'd0, b & mask};
    sa = ua;
    sb = ub;
    if (a[w-1]) sa = ua - (130'sd1 <<< w);
    if (b[w-1]) sb = ub - (130'sd1 <<< w);
    case (f)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = (ua * ub) >>> w;
      3'd4: r = (ub == 0) ? -130'sd1 : sa / sb;
      3'd5: r = (ub == 0) ? -130'sd1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r[63:0] & mask;
  endfunction

  function automatic int ref_latency(int w, logic [2:0] f, logic [63:0] a, logic [63:0] b);
    logic [63:0] mask = wmask(w);
    logic [63:0] min_neg = 64'd1 << (w - 1);
    logic special = f[2] && ((b == 0) || (!f[0] && (a == min_neg) && (b == mask)));
    return special ? 1 : w + 1;
  endfunction

  function automatic logic [63:0] rnd_val(int w);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'd1 << (w - 1);
      3:       v = 64'($urandom_range(1, 10));
      4:       v = -64'($urandom_range(1, 10));
      default: v = {$urandom, $urandom};
    endcase
    return v & wmask(w);
  endfunction

  task automatic set_req(input int idx, input logic v, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b);
    sv[idx] = v;
    case (idx)
      0:       begin f3_32 = f; a32 = a[31:0]; b32 = b[31:0]; end
      1:       begin f3_8  = f; a8  = a[7:0];  b8  = b[7:0];  end
      default: begin f3_64 = f; a64 = a;       b64 = b;       end
    endcase
  endtask

  // Issue one request and wait (bounded) for result_valid; lat = edges from request
  task automatic run_op(input int idx, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    chk("start_ready_before_req", {63'd0, sr[idx]}, 64'd1);
    set_req(idx, 1'b1, f, a, b);
    @(posedge clk); #1;
    set_req(idx, 1'b0, ~f, ~a, ~b);   // operands must have been latched
    lat = 1;
    while (!rv[idx] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = get_res(idx);
  endtask

  task automatic release_res(input int idx);
    rr[idx] = 1'b1;
    @(posedge clk); #1;
    rr[idx] = 1'b0;
  endtask

  logic [63:0] res, exp, held;
  int lat, highs;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,        32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,        32'd2,        33};
    vecs[8]  = '{3'b101, 32'h1234,      32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b110, 32'h1234,      32'd0,        32'h1234,     1};
    vecs[10] = '{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h0,        1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {61'd0, bz}, 64'd0);
    chk("reset_result_valid", {61'd0, rv}, 64'd0);
    chk("reset_start_ready", {61'd0, sr}, 64'd7);
    chk("reset_result32", {32'd0, res32}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      run_op(0, vecs[i].f3, {32'd0, vecs[i].a}, {32'd0, vecs[i].b}, res, lat);
      chk($sformatf("vec%0d_result", i), res, {32'd0, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      release_res(0);
      chk($sformatf("vec%0d_valid_dropped", i), {63'd0, rv[0]}, 64'd0);
    end

    // Handshake: hold result in DONE, then overlap result_ready with a new request
    run_op(0, 3'b000, 64'd3, 64'd4, res, lat);
    chk("hs_first_result", res, 64'd12);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hs_hold%0d_valid", i), {63'd0, rv[0]}, 64'd1);
      chk($sformatf("hs_hold%0d_result", i), {32'd0, res32}, 64'd12);
      chk($sformatf("hs_hold%0d_start_ready", i), {63'd0, sr[0]}, 64'd0);
    end
    rr[0] = 1'b1;
    set_req(0, 1'b1, 3'b011, 64'h10000, 64'h30000);
    @(posedge clk); #1;
    rr[0] = 1'b0;
    chk("hs_idle_valid", {63'd0, rv[0]}, 64'd0);
    chk("hs_idle_start_ready", {63'd0, sr[0]}, 64'd1);
    chk("hs_idle_busy", {63'd0, bz[0]}, 64'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b000, 64'd0, 64'd0);
    chk("hs_accept_busy", {63'd0, bz[0]}, 64'd1);
    lat = 0;
    while (!rv[0] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs_second_latency", 64'(lat), 64'd32);
    chk("hs_second_result", {32'd0, res32}, 64'd3);
    release_res(0);
    held = 64'd3;

    // Flush in IDLE blocks acceptance
    set_req(0, 1'b1, 3'b000, 64'd2, 64'd2);
    fl[0] = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_busy", {63'd0, bz[0]}, 64'd0);
    fl[0] = 1'b0;
    set_req(0, 1'b0, 3'b000, 64'd0, 64'd0);

    // Flush in CALC cycle 10 of a DIV
    set_req(0, 1'b1, 3'b100, 64'd1000, 64'd3);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b000, 64'd0, 64'd0);
    repeat (9) begin @(posedge clk); #1; end
    chk("flush_pre_busy", {63'd0, bz[0]}, 64'd1);
    fl[0] = 1'b1;
    @(posedge clk); #1;
    fl[0] = 1'b0;
    chk("flush_busy", {63'd0, bz[0]}, 64'd0);
    chk("flush_valid", {63'd0, rv[0]}, 64'd0);
    chk("flush_start_ready", {63'd0, sr[0]}, 64'd1);
    chk("flush_result_kept", {32'd0, res32}, held);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rv[0]) highs++;
    end
    chk("flush_no_valid", 64'(highs), 64'd0);
    run_op(0, 3'b000, 64'd3, 64'd5, res, lat);
    chk("after_flush_mul", res, 64'd15);
    chk("after_flush_latency", 64'(lat), 64'd33);
    release_res(0);

    // Asynchronous reset between clock edges mid-CALC
    set_req(0, 1'b1, 3'b000, 64'h1234, 64'h5678);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b000, 64'd0, 64'd0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, bz[0]}, 64'd0);
    chk("arst_valid", {63'd0, rv[0]}, 64'd0);
    chk("arst_result", {32'd0, res32}, 64'd0);
    chk("arst_start_ready", {63'd0, sr[0]}, 64'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(0, 3'b000, 64'h1234, 64'h5678, res, lat);
    chk("arst_resume_result", res, 64'h0626_0060);
    chk("arst_resume_latency", 64'(lat), 64'd33);
    release_res(0);

    // Random sweep over all three widths
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < 40; n++) begin
        int w;
        logic [2:0] f;
        logic [63:0] a, b;
        w = width_of(idx);
        f = 3'($urandom_range(0, 7));
        a = rnd_val(w);
        b = rnd_val(w);
        exp = ref_model(w, f, a, b);
        run_op(idx, f, a, b, res, lat);
        chk($sformatf("rnd_x%0d_%0d_f%0d_a%0h_b%0h_result", w, n, f, a, b), res, exp);
        chk($sformatf("rnd_x%0d_%0d_latency", w, n), 64'(lat), 64'(ref_latency(w, f, a, b)));
        release_res(idx);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in XLEN.
- Sits beside the single-cycle ALU in the EX stage. The core stalls on start_ready/result_valid.
- Decodes the M-extension funct3 directly; the core's ALU control routes funct7=0000001 R-type instructions here.
- One operation in flight at a time. Radix-2 shift-add multiply, restoring divide.

Parameters:
- XLEN, 32, operand/result width (power of two, >=8).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start_valid  in  1  request present.
- start_ready  out  1  unit can accept a request (high only in IDLE).
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- flush  in  1  synchronous kill of the current operation.
- busy  out  1  state != IDLE.
- result_valid  out  1  result available (high only in DONE).
- result  out  XLEN  result; held stable while result_valid.
- result_ready  in  1  consumer takes result.

Behaviour:
- Reset (async, any state): state=IDLE, result=0, counter=0, internal accumulators=0. Outputs: result_valid=0, busy=0, start_ready=1.
- States are IDLE, CALC and DONE.
- IDLE:
  - Accept on start_valid & start_ready & !flush.
  - Latch funct3, operands and sign information.
  - Operands are converted to magnitudes:
    - Signed: MULH (both), MULHSU (op_a only), DIV/REM (both).
    - Unsigned: MULHU, DIVU, REMU.
    - MUL: signedness is irrelevant to the low word; treated as unsigned.
  - Record result sign:
    - MUL*: sign_a^sign_b.
    - DIV: sign_a^sign_b.
    - REM: sign_a.
- Special cases, detected at acceptance, go IDLE->DONE directly (result_valid on the next cycle):
  - Divide by zero (op_b==0):
    - DIV/DIVU: result = all ones.
    - REM/REMU: result = op_a.
  - Signed overflow (DIV/REM, op_a = 1<<(XLEN-1), op_b = all ones):
    - DIV: result = op_a.
    - REM: result = 0.
- Otherwise go IDLE->CALC with counter=0.
- CALC, one iteration per cycle, exactly XLEN cycles:
  - Multiply: 2*XLEN-bit product accumulator, shift-add on multiplier LSB.
  - Divide: restoring step on a {remainder, quotient} pair; remainder is XLEN+1 bits.
  - On the cycle counter reaches XLEN-1:
    - Apply the sign fix: two's complement of the 2*XLEN-bit product, quotient or remainder when the result sign is set.
    - Select the output word:
      - MUL: product low word.
      - MULH/MULHSU/MULHU: product high word.
      - DIV/DIVU: quotient.
      - REM/REMU: remainder low XLEN bits.
    - Register the result and go to DONE.
- Latency: acceptance in cycle 0; result_valid first high in cycle XLEN+1 (normal) or cycle 1 (special case).
- DONE:
  - result_valid=1; result held stable.
  - On result_ready, go to IDLE; result_valid drops the next cycle.
  - start_ready=0 in DONE, so there is no back-to-back overlap. The earliest next acceptance is the cycle after the handshake.
- flush:
  - Priority over all other events.
  - In CALC or DONE: go to IDLE next cycle, result_valid=0, no result delivered. The result register keeps its last value.
  - In IDLE with start_valid: request is not accepted.
- Inputs are sampled only at acceptance. op_a/op_b/funct3 changes during CALC have no effect.
- result_ready outside DONE is ignored.
- All arithmetic is modulo 2^XLEN for outputs. No exceptions or flags are raised.

Test Plan:
- Multiply ops (XLEN=32), each checked by waveform:
  - MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; result_valid first high 33 cycles after acceptance.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide, op_a=0xFFFFFFF9 (-7), op_b=2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, result_valid 1 cycle after acceptance:
  - DIVU 0x1234/0 -> 0xFFFFFFFF.
  - REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Handshake: hold result_ready=0 for 5 cycles in DONE -> result_valid and result stable. Assert result_ready with start_valid high -> next acceptance exactly 2 cycles later; start_ready=0 throughout DONE.
- Flush: flush at CALC cycle 10 of a DIV -> IDLE next cycle, result_valid never asserts, start_ready=1. A following MUL 3x5 returns 15.
- Async reset: assert rst mid-CALC between clock edges -> busy=0, result_valid=0, result=0, start_ready=1 immediately. Operation resumes normally after deassert.
- Parameter sweep: repeat random signed/unsigned vectors at XLEN=8 and XLEN=64 against a reference model. Latency is XLEN+1.
